// File: rtl/peak_finder_core.sv
// peak_finder_core
// Streams one frame of signed samples per armed request and reports the
// largest sample together with its zero-based index within the frame.
//
// Optional feature (compile-time macro PEAK_FINDER_THRESHOLD_EN):
//   defined   - a sample qualifies only if it is >= cfg_threshold (signed)
//   undefined - cfg_threshold is ignored and every sample qualifies
//
// Ports
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   cfg_start            pulse that arms one frame (accepted only when idle)
//   cfg_frame_len        samples per frame, latched on an accepted cfg_start
//   cfg_threshold        signed qualification threshold
//   s_axis_*             sample stream (tdata, tvalid, tready, tlast)
//   res_valid/res_ready  result handshake
//   res_peak_value       peak sample value
//   res_peak_index       peak index within the frame
//   res_early            frame ended on tlast before cfg_frame_len samples
//   res_hit              at least one sample qualified
//   busy                 high while acquiring or holding a result
module peak_finder_core #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  cfg_start,
   input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
   input  logic [DATA_WIDTH-1:0] cfg_threshold,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] res_peak_value,
   output logic [LEN_WIDTH-1:0]  res_peak_index,
   output logic                  res_early,
   output logic                  res_hit,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACQ    = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   state_t                        r_state;
   logic        [LEN_WIDTH-1:0]   r_len;
   logic        [LEN_WIDTH-1:0]   r_count;
   logic signed [DATA_WIDTH-1:0]  r_peak_value;
   logic        [LEN_WIDTH-1:0]   r_peak_index;
   logic                          r_early;
   logic                          r_hit;
   logic                          r_tready;
   logic                          r_res_valid;
   logic                          r_busy;

   logic signed [DATA_WIDTH-1:0]  w_sample;
   logic        [LEN_WIDTH-1:0]   w_last_idx;
   logic                          w_beat;
   logic                          w_qual;
   logic                          w_capture;
   logic                          w_last;

   assign w_sample   = s_axis_tdata;
   assign w_last_idx = r_len - LEN_WIDTH'(1);
   assign w_beat     = s_axis_tvalid & r_tready;

`ifdef PEAK_FINDER_THRESHOLD_EN
   assign w_qual = (w_sample >= $signed(cfg_threshold));
`else
   logic w_unused_thr;
   assign w_qual       = 1'b1;
   assign w_unused_thr = ^cfg_threshold;
`endif

   // First qualifying sample always captures; later ones only on a strict
   // increase, so ties keep the earliest index.
   assign w_capture = w_qual & (~r_hit | (w_sample > r_peak_value));

   // Count never passes len-1, so the frame always ends before it can wrap.
   assign w_last = (r_count == w_last_idx) | s_axis_tlast;

   // Frame control FSM with registered handshake and status outputs
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state      <= ST_IDLE;
         r_len        <= '0;
         r_count      <= '0;
         r_peak_value <= '0;
         r_peak_index <= '0;
         r_early      <= 1'b0;
         r_hit        <= 1'b0;
         r_tready     <= 1'b0;
         r_res_valid  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cfg_start && (cfg_frame_len != '0)) begin
                  r_state      <= ST_ACQ;
                  r_len        <= cfg_frame_len;
                  r_count      <= '0;
                  r_peak_value <= '0;
                  r_peak_index <= '0;
                  r_early      <= 1'b0;
                  r_hit        <= 1'b0;
                  r_tready     <= 1'b1;
                  r_busy       <= 1'b1;
               end
            end

            ST_ACQ: begin
               if (w_beat) begin
                  if (w_capture) begin
                     r_peak_value <= w_sample;
                     r_peak_index <= r_count;
                     r_hit        <= 1'b1;
                  end
                  if (w_last) begin
                     r_state     <= ST_RESULT;
                     r_tready    <= 1'b0;
                     r_res_valid <= 1'b1;
                     r_early     <= s_axis_tlast & (r_count < w_last_idx);
                  end else begin
                     r_count <= r_count + LEN_WIDTH'(1);
                  end
               end
            end

            ST_RESULT: begin
               if (res_ready) begin
                  r_state     <= ST_IDLE;
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end

            default: begin
               r_state     <= ST_IDLE;
               r_tready    <= 1'b0;
               r_res_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign s_axis_tready  = r_tready;
   assign res_valid      = r_res_valid;
   assign res_peak_value = r_peak_value;
   assign res_peak_index = r_peak_index;
   assign res_early      = r_early;
   assign res_hit        = r_hit;
   assign busy           = r_busy;

endmodule

// File: tb/tb_peak_finder_core.sv
// Testbench for peak_finder_core: directed frames checked against a
// frame-level reference model on every cycle, plus literal expectations.
module tb_peak_finder_core;

   localparam int unsigned DW = 16;
   localparam int unsigned LW = 16;

   logic          ACLK          = 1'b0;
   logic          ARESETN       = 1'b0;
   logic          cfg_start     = 1'b0;
   logic [LW-1:0] cfg_frame_len = '0;
   logic [DW-1:0] cfg_threshold = '0;
   logic [DW-1:0] s_axis_tdata  = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tlast  = 1'b0;
   logic          res_ready     = 1'b0;
   logic          s_axis_tready;
   logic          res_valid;
   logic [DW-1:0] res_peak_value;
   logic [LW-1:0] res_peak_index;
   logic          res_early;
   logic          res_hit;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   peak_finder_core #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .cfg_start     (cfg_start),
      .cfg_frame_len (cfg_frame_len),
      .cfg_threshold (cfg_threshold),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_peak_value(res_peak_value),
      .res_peak_index(res_peak_index),
      .res_early     (res_early),
      .res_hit       (res_hit),
      .busy          (busy)
   );

   initial forever #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   // phase: 0 idle, 1 acquiring, 2 result pending
   int m_phase = 0;
   int m_len   = 0;
   int m_frame[$];
   bit m_qual[$];
   int m_val   = 0;
   int m_idx   = 0;
   bit m_early = 1'b0;
   bit m_hit   = 1'b0;

   function automatic bit qualifies(input int v);
`ifdef PEAK_FINDER_THRESHOLD_EN
      return v >= int'($signed(cfg_threshold));
`else
      return (v == v);
`endif
   endfunction

   // Peak = maximum over qualifying samples; index = first position holding it.
   task automatic model_result();
      int best;
      bit any;
      any  = 1'b0;
      best = 0;
      foreach (m_frame[i])
         if (m_qual[i] && (!any || m_frame[i] > best)) begin
            best = m_frame[i];
            any  = 1'b1;
         end
      m_hit = any;
      m_val = any ? best : 0;
      m_idx = 0;
      if (any)
         for (int i = m_frame.size() - 1; i >= 0; i--)
            if (m_qual[i] && m_frame[i] == best) m_idx = i;
      m_early = (m_frame.size() < m_len);
   endtask

   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         m_phase = 0;
         m_frame.delete();
         m_qual.delete();
         m_val = 0; m_idx = 0; m_early = 1'b0; m_hit = 1'b0;
      end else begin
         case (m_phase)
            0: if (cfg_start && cfg_frame_len != 0) begin
                  m_phase = 1;
                  m_len   = int'(cfg_frame_len);
                  m_frame.delete();
                  m_qual.delete();
                  m_val = 0; m_idx = 0; m_early = 1'b0; m_hit = 1'b0;
               end
            1: if (s_axis_tvalid) begin
                  m_frame.push_back(int'($signed(s_axis_tdata)));
                  m_qual.push_back(qualifies(int'($signed(s_axis_tdata))));
                  if (m_frame.size() == m_len || s_axis_tlast) begin
                     model_result();
                     m_phase = 2;
                  end
               end
            2: if (res_ready) m_phase = 0;
            default: m_phase = 0;
         endcase
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle
   always @(negedge ACLK) begin
      chk("tready", s_axis_tready, (m_phase == 1));
      chk("res_valid", res_valid, (m_phase == 2));
      chk("busy", busy, (m_phase != 0));
      if (m_phase == 2 || !ARESETN) begin
         chk("peak_value", $signed(res_peak_value), m_val);
         chk("peak_index", res_peak_index, m_idx);
         chk("early", res_early, m_early);
         chk("hit", res_hit, m_hit);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic start(input int len);
      cfg_start     = 1'b1;
      cfg_frame_len = LW'(len);
      tick();
      cfg_start     = 1'b0;
   endtask

   task automatic send(input int v, input bit last);
      s_axis_tdata  = DW'(v);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = last;
      tick();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic ack();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic chk_result(input string tag, input int v, input int idx,
                             input bit early, input bit hit);
      chk({tag, "_valid"}, res_valid, 1);
      chk({tag, "_value"}, $signed(res_peak_value), v);
      chk({tag, "_index"}, res_peak_index, idx);
      chk({tag, "_early"}, res_early, early);
      chk({tag, "_hit"}, res_hit, hit);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tready"}, s_axis_tready, 0);
      chk({tag, "_valid"}, res_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_value"}, res_peak_value, 0);
      chk({tag, "_index"}, res_peak_index, 0);
      chk({tag, "_early"}, res_early, 0);
      chk({tag, "_hit"}, res_hit, 0);
   endtask

   initial begin
      int f1[8];
      int f2[4];
      f1 = '{3, -2, 7, 7, 1, 0, 5, -9};

      #1;
      chk_reset_outputs("reset");
      tick();
      tick();
      ARESETN = 1'b1;
      tick();

      // Continuous frame, tie on 7 keeps the first index
      start(8);
      foreach (f1[i]) send(f1[i], 1'b0);
      chk_result("f1", 7, 2, 1'b0, 1'b1);
      ack();
      chk("f1_idle_busy", busy, 0);

      // Early termination on tlast
      start(8);
      send(4, 1'b0);
      send(9, 1'b0);
      send(2, 1'b1);
      chk("f2_tready", s_axis_tready, 0);
      chk_result("f2", 9, 1, 1'b1, 1'b1);
      ack();

      // Most-negative samples, result held under backpressure
      cfg_threshold = DW'(-32768);
      start(4);
      repeat (4) send(-32768, 1'b0);
      repeat (10) tick();
      chk_result("f3", -32768, 0, 1'b0, 1'b1);
      chk("f3_busy", busy, 1);
      ack();

      // Gaps in tvalid, cfg_start during ACQ ignored, negative tie
      start(4);
      send(-5, 1'b0);
      tick();
      cfg_start = 1'b1;
      cfg_frame_len = LW'(2);
      tick();
      cfg_start = 1'b0;
      send(-3, 1'b0);
      send(-3, 1'b0);
      send(-8, 1'b0);
      chk_result("f4", -3, 1, 1'b0, 1'b1);
      ack();

      // tvalid while idle is not consumed
      s_axis_tdata  = DW'(100);
      s_axis_tvalid = 1'b1;
      tick();
      chk("idle_tready", s_axis_tready, 0);
      s_axis_tvalid = 1'b0;
      start(2);
      send(100, 1'b0);
      send(50, 1'b0);
      chk_result("f5", 100, 0, 1'b0, 1'b1);
      ack();

      // Threshold qualification
      cfg_threshold = DW'(10);
      f2 = '{5, 12, 8, 11};
      start(4);
      foreach (f2[i]) send(f2[i], 1'b0);
      chk_result("f6", 12, 1, 1'b0, 1'b1);
      ack();
      start(4);
      for (int i = 1; i <= 4; i++) send(i, 1'b0);
`ifdef PEAK_FINDER_THRESHOLD_EN
      chk_result("f7", 0, 0, 1'b0, 1'b0);
`else
      chk_result("f7", 4, 3, 1'b0, 1'b1);
`endif
      ack();

      // Reset asserted during beat 3 of an active frame
      start(8);
      send(1, 1'b0);
      send(2, 1'b0);
      send(3, 1'b0);
      s_axis_tdata  = DW'(40);
      s_axis_tvalid = 1'b1;
      ARESETN       = 1'b0;
      #1;
      chk_reset_outputs("rst_acq");
      tick();
      s_axis_tvalid = 1'b0;
      ARESETN       = 1'b1;
      repeat (3) tick();
      chk("post_rst_valid", res_valid, 0);
      chk("post_rst_busy", busy, 0);

      // Zero-length start is ignored
      start(0);
      tick();
      chk("len0_busy", busy, 0);
      chk("len0_tready", s_axis_tready, 0);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
